// File: rtl/mvm_pkg.sv
// Shared sizing, timing constants and FSM encoding for the MVM host driver.
package mvm_pkg;

  localparam int K         = 8;
  localparam int P         = 8;
  localparam int B         = 12;
  localparam int RW        = 2 * B;
  localparam int MAT_LEN   = K * P;
  localparam int FRAME_LEN = MAT_LEN + P;
  localparam int TIMEOUT   = 255;
  localparam int RES_DELAY = 2;

  localparam int FA_W  = $clog2(FRAME_LEN);
  localparam int SC_W  = $clog2(MAT_LEN);
  localparam int ROW_W = $clog2(K);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CAP_W = $clog2(RES_DELAY + K);

  typedef enum logic [3:0] {
    IDLE, FILL, CMD_M, SEND_M, CMD_V, SEND_V, GO, WAIT, CAPT, DRAIN
  } state_t;

endpackage

// File: rtl/mvm_host_driver_mem.sv
// Simple dual-port memory with one write port and a registered read port.
module mvm_host_driver_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 72,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mvm_host_driver.sv
// Buffers one matrix/vector frame, replays it to the MVM accelerator, and
// streams the captured result rows back out.
module mvm_host_driver
  import mvm_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [B-1:0]  in_data,
  output logic          loadMatrix,
  output logic          loadVector,
  output logic          start,
  output logic [B-1:0]  mvm_data,
  input  logic          done,
  input  logic [RW-1:0] mvm_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err_timeout
);

  state_t state, state_nxt;

  logic [FA_W-1:0]  fill_cnt;
  logic [SC_W-1:0]  send_cnt;
  logic [TO_W-1:0]  tmo_cnt;
  logic [CAP_W-1:0] cap_cnt;
  logic [ROW_W-1:0] row_cnt;

  logic             frm_we;
  logic [FA_W-1:0]  frm_raddr;
  logic [B-1:0]     frm_rdata;
  logic             res_we;
  logic [ROW_W-1:0] res_waddr;
  logic [ROW_W-1:0] res_raddr;
  logic [RW-1:0]    res_rdata;
  logic             send_done;
  logic             tmo_hit;
  logic             cap_done;

  assign frm_we    = in_valid && in_ready;
  assign send_done = (state == SEND_M) ? (send_cnt == SC_W'(MAT_LEN - 1))
                                       : (send_cnt == SC_W'(P - 1));
  // The start-pulse cycle counts toward the timeout, so WAIT gives up one early.
  assign tmo_hit   = (tmo_cnt == TO_W'(TIMEOUT - 2));
  assign cap_done  = (cap_cnt == CAP_W'(RES_DELAY + K - 2));
  assign res_we    = (state == CAPT) && (cap_cnt >= CAP_W'(RES_DELAY - 1));
  assign res_waddr = ROW_W'(cap_cnt - CAP_W'(RES_DELAY - 1));

  assign mvm_data  = (state == SEND_M || state == SEND_V) ? frm_rdata : '0;
  assign out_data  = (state == DRAIN) ? res_rdata : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start      = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    frm_raddr  = '0;
    res_raddr  = row_cnt;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && fill_cnt == FA_W'(FRAME_LEN - 1)) state_nxt = CMD_M;
      end
      CMD_M: begin
        loadMatrix = 1'b1;
        state_nxt  = SEND_M;
      end
      SEND_M: begin
        // Read one word ahead to hide the registered-read latency.
        frm_raddr = FA_W'(send_cnt) + 1'b1;
        if (send_done) state_nxt = CMD_V;
      end
      CMD_V: begin
        loadVector = 1'b1;
        frm_raddr  = FA_W'(MAT_LEN);
        state_nxt  = SEND_V;
      end
      SEND_V: begin
        frm_raddr = FA_W'(MAT_LEN) + FA_W'(send_cnt) + 1'b1;
        if (send_done) state_nxt = GO;
      end
      GO: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done)         state_nxt = CAPT;
        else if (tmo_hit) state_nxt = IDLE;
      end
      CAPT: begin
        if (cap_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row_cnt == ROW_W'(K - 1));
        if (out_ready) begin
          res_raddr = row_cnt + 1'b1;
          if (out_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt    <= '0;
      send_cnt    <= '0;
      tmo_cnt     <= '0;
      cap_cnt     <= '0;
      row_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (frm_we) fill_cnt <= (state_nxt == CMD_M) ? '0 : fill_cnt + 1'b1;

      if ((state == SEND_M || state == SEND_V) && !send_done) send_cnt <= send_cnt + 1'b1;
      else                                                    send_cnt <= '0;

      tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
      cap_cnt <= (state == CAPT) ? cap_cnt + 1'b1 : '0;

      if (state != DRAIN)  row_cnt <= '0;
      else if (out_ready)  row_cnt <= row_cnt + 1'b1;

      if (state == WAIT && !done && tmo_hit) err_timeout <= 1'b1;
    end
  end

  mvm_host_driver_mem #(.WIDTH(B), .DEPTH(FRAME_LEN), .AW(FA_W)) u_frame_mem (
    .clk   (clk),
    .we    (frm_we),
    .waddr (fill_cnt),
    .wdata (in_data),
    .raddr (frm_raddr),
    .rdata (frm_rdata)
  );

  mvm_host_driver_mem #(.WIDTH(RW), .DEPTH(K), .AW(ROW_W)) u_result_mem (
    .clk   (clk),
    .we    (res_we),
    .waddr (res_waddr),
    .wdata (mvm_result),
    .raddr (res_raddr),
    .rdata (res_rdata)
  );

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver with a behavioural accelerator model.
module tb_mvm_host_driver;
  import mvm_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  in_data;
  logic          loadMatrix, loadVector, start;
  logic [B-1:0]  mvm_data;
  logic          done;
  logic [RW-1:0] mvm_result;
  logic          out_valid, out_ready, out_last;
  logic [RW-1:0] out_data;
  logic          busy, err_timeout;

  always #5 clk = ~clk;

  mvm_host_driver dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .loadMatrix  (loadMatrix),
    .loadVector  (loadVector),
    .start       (start),
    .mvm_data    (mvm_data),
    .done        (done),
    .mvm_result  (mvm_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- accelerator model (acts 2 time units after each edge)
  logic signed [B-1:0] ma [MAT_LEN];
  logic signed [B-1:0] mx [P];
  logic [RW-1:0]       y_m [K];
  int  cyc, m_left, v_left, done_at, lm_cyc, lv_cyc, st_cyc;
  bit  done_en;
  int  lat;

  initial begin
    int acc;
    int k;
    done = 1'b0; mvm_result = '0;
    cyc = 0; m_left = 0; v_left = 0; done_at = -100;
    lm_cyc = 0; lv_cyc = 0; st_cyc = 0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (m_left > 0) begin ma[MAT_LEN - m_left] = mvm_data; m_left--; end
      if (v_left > 0) begin mx[P - v_left] = mvm_data; v_left--; end
      if (loadMatrix) begin m_left = MAT_LEN; lm_cyc = cyc; end
      if (loadVector) begin v_left = P; lv_cyc = cyc; end
      if (start) begin
        st_cyc = cyc;
        for (int r = 0; r < K; r++) begin
          acc = 0;
          for (int c = 0; c < P; c++) acc += int'(ma[r*P + c]) * int'(mx[c]);
          y_m[r] = acc[RW-1:0];
        end
        if (done_en) done_at = cyc + lat;
      end
      if (reset) begin m_left = 0; v_left = 0; done_at = -100; end
      // A stray done while the vector is loading must be ignored by the driver.
      done = (cyc == done_at) || loadVector;
      k = cyc - done_at - RES_DELAY;
      mvm_result = (k >= 0 && k < K) ? y_m[k] : RW'($urandom);
    end
  end

  // ---------------- vector table
  typedef struct packed {
    bit                  gap;
    bit                  ident;
    logic [B-1:0]        a_val;
    logic [P-1:0][B-1:0] x;
    logic [7:0]          stall;
    logic [K-1:0][RW-1:0] y;
  } vec_t;

  localparam int NV = 5;
  vec_t         tbl [NV];
  logic [B-1:0] fw [FRAME_LEN];

  task automatic build_frame(input int i);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < P; c++)
        fw[r*P + c] = tbl[i].ident ? B'(r == c) : tbl[i].a_val;
    for (int c = 0; c < P; c++) fw[MAT_LEN + c] = tbl[i].x[c];
  endtask

  task automatic send_frame(input bit gap);
    int  guard;
    bit  acc;
    for (int w = 0; w < FRAME_LEN; w++) begin
      in_valid = 1'b1;
      in_data  = fw[w];
      guard    = 0;
      do begin
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        check($sformatf("fill_accept_w%0d", w), 32'(acc), 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (gap) begin
        in_valid = 1'b0;
        in_data  = B'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int i);
    vec_t v;
    int   g;
    int   mark;
    v    = tbl[i];
    mark = cyc;
    lat  = 3 + i;
    build_frame(i);
    out_ready = (v.stall == 0);
    send_frame(v.gap);
    g = 0;
    while (!out_valid && g < 500) begin @(posedge clk); #1; g++; end
    check($sformatf("f%0d_out_valid", i), 32'(out_valid), 32'd1);
    if (v.stall != 0) begin
      for (int s = 0; s < int'(v.stall); s++) begin
        in_valid = 1'b1;
        in_data  = B'($urandom);
        check($sformatf("f%0d_stall%0d_data", i, s), out_data, v.y[0]);
        check($sformatf("f%0d_stall%0d_in_ready", i, s), 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    for (int r = 0; r < K; r++) begin
      g = 0;
      while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
      check($sformatf("f%0d_row%0d_data", i, r), out_data, v.y[r]);
      check($sformatf("f%0d_row%0d_last", i, r), 32'(out_last), 32'(r == K - 1));
      @(posedge clk); #1;
    end
    check($sformatf("f%0d_idle_after", i), 32'(busy), 32'd0);
    check($sformatf("f%0d_lm_seen", i), 32'(lm_cyc > mark), 32'd1);
    check($sformatf("f%0d_lv_offset", i), 32'(lv_cyc - lm_cyc), 32'd65);
    check($sformatf("f%0d_start_offset", i), 32'(st_cyc - lv_cyc), 32'd9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    int xs3 [P] = '{100, -200, 300, -400, 500, -600, 700, -800};

    for (int i = 0; i < NV; i++) tbl[i] = '0;
    for (int r = 0; r < K; r++) begin
      tbl[0].x[r] = B'(r + 1);
      tbl[0].y[r] = RW'(r + 1);
    end
    tbl[0].ident = 1'b1;
    tbl[1]       = tbl[0];
    tbl[1].gap   = 1'b1;
    tbl[2].a_val = -12'sd2048;
    for (int r = 0; r < K; r++) begin
      tbl[2].x[r] = -12'sd2048;
      tbl[2].y[r] = 24'h000000;
      tbl[3].x[r] = B'(xs3[r]);
      tbl[3].y[r] = 24'hFFFE70;
      tbl[4].x[r] = 12'd2047;
      tbl[4].y[r] = 24'hFF8008;
    end
    tbl[3].a_val = 12'd1;
    tbl[4].a_val = 12'd2047;
    tbl[4].stall = 8'd20;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    done_en = 1'b1; lat = 4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmds", {29'd0, loadMatrix, loadVector, start}, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mvm_data", 32'(mvm_data), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);

    for (int i = 0; i < NV; i++) run_frame(i);

    // Accelerator never answers: timeout counted from the start pulse.
    done_en = 1'b0;
    build_frame(0);
    send_frame(1'b0);
    g = 0;
    while (!start && g < 200) begin @(posedge clk); #1; g++; end
    check("tmo_start_seen", 32'(start), 32'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!err_timeout && n < 400);
    check("tmo_cycles", 32'(n), 32'd255);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_in_ready", 32'(in_ready), 32'd1);
    done_en = 1'b1;

    run_frame(0);
    check("tmo_sticky", 32'(err_timeout), 32'd1);

    // Reset while the matrix is being replayed.
    for (int w = 0; w < FRAME_LEN; w++) fw[w] = B'(w + 100);
    send_frame(1'b0);
    g = 0;
    while (!loadMatrix && g < 10) begin @(posedge clk); #1; g++; end
    check("mrst_lm_seen", 32'(loadMatrix), 32'd1);
    @(posedge clk); #1;
    check("mrst_word0", 32'(mvm_data), 32'd100);
    repeat (30) begin @(posedge clk); #1; end
    check("mrst_word30", 32'(mvm_data), 32'd130);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_cmds", {29'd0, loadMatrix, loadVector, start}, 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_mvm_data", 32'(mvm_data), 32'd0);
    check("mrst_err_cleared", 32'(err_timeout), 32'd0);

    run_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
